// File: rtl/modulus_counter.sv
// Up/down modulus counter with synchronous clear/set/load, a cascade carry,
// and a registered one-cycle wrap pulse.
module modulus_counter #(
    parameter int              lpm_width   = 8,
    parameter longint unsigned lpm_modulus = 0,
    parameter longint unsigned lpm_svalue  = (64'd1 << lpm_width) - 64'd1
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 clk_en,
    input  logic                 cnt_en,
    input  logic                 cin,
    input  logic                 updown,
    input  logic [lpm_width-1:0] data,
    input  logic                 sclr,
    input  logic                 sset,
    input  logic                 sload,
    output logic [lpm_width-1:0] q,
    output logic                 cout,
    output logic                 wrap
);

    // A modulus of zero selects the full binary range of the counter.
    localparam longint unsigned MODULUS =
        (lpm_modulus == 0) ? (64'd1 << lpm_width) : lpm_modulus;
    localparam logic [lpm_width-1:0] TOP = lpm_width'(MODULUS - 64'd1);
    localparam logic [lpm_width-1:0] SET_VALUE =
        (lpm_svalue >= MODULUS) ? TOP : lpm_width'(lpm_svalue);

    logic                 count;
    logic                 at_top;
    logic                 at_zero;
    logic [lpm_width-1:0] load_value;
    logic [lpm_width-1:0] q_next;
    logic                 wrap_next;

    assign count      = cnt_en & cin;
    assign at_top     = (q == TOP);
    assign at_zero    = (q == '0);
    assign cout       = count & (updown ? at_top : at_zero);
    assign load_value = (64'(data) >= MODULUS) ? TOP : data;

    // Only a counting step can flag a wrap; clear/set/load always suppress it.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (sclr) begin
            q_next = '0;
        end else if (sset) begin
            q_next = SET_VALUE;
        end else if (sload) begin
            q_next = load_value;
        end else if (count) begin
            wrap_next = cout;
            if (updown) begin
                q_next = at_top ? '0 : q + lpm_width'(1);
            end else begin
                q_next = at_zero ? TOP : q - lpm_width'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (clk_en) begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_modulus_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares them one step after each rising edge (or on demand for async checks).
module tb_modulus_counter;

    logic       clock = 1'b0;
    logic       aclr;
    logic       clk_en, cnt_en, cin, updown, sclr, sset, sload;
    logic [3:0] data;
    logic [3:0] q_a, q_b;
    logic       cout_a, cout_b, wrap_a, wrap_b;

    typedef struct {
        string      name;
        bit         sel;
        logic [3:0] q;
        logic       wrap;
        logic       cout;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // control vector order: {clk_en, cnt_en, cin, updown, sclr, sset, sload}
    localparam logic [6:0] UP   = 7'b1111000;
    localparam logic [6:0] DOWN = 7'b1110000;

    modulus_counter #(.lpm_width(4), .lpm_modulus(10)) dut_a (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .cnt_en(cnt_en), .cin(cin),
        .updown(updown), .data(data), .sclr(sclr), .sset(sset), .sload(sload),
        .q(q_a), .cout(cout_a), .wrap(wrap_a)
    );

    modulus_counter #(.lpm_width(4), .lpm_modulus(0)) dut_b (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .cnt_en(cnt_en), .cin(cin),
        .updown(updown), .data(data), .sclr(sclr), .sset(sset), .sload(sload),
        .q(q_b), .cout(cout_b), .wrap(wrap_b)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            #1 -> sample_ev;
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [3:0] aq;
        logic       aw, ac;
        forever begin
            @(sample_ev);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                aq = e.sel ? q_b : q_a;
                aw = e.sel ? wrap_b : wrap_a;
                ac = e.sel ? cout_b : cout_a;
                checks += 3;
                if (aq !== e.q) begin
                    errors++;
                    $display("[TB] FAIL %s q actual %0d expected %0d", e.name, aq, e.q);
                end
                if (aw !== e.wrap) begin
                    errors++;
                    $display("[TB] FAIL %s wrap actual %b expected %b", e.name, aw, e.wrap);
                end
                if (ac !== e.cout) begin
                    errors++;
                    $display("[TB] FAIL %s cout actual %b expected %b", e.name, ac, e.cout);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout actual running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void push_exp(input string nm, input bit sel,
                                     input logic [3:0] eq, input logic ew, input logic ec);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.q    = eq;
        e.wrap = ew;
        e.cout = ec;
        sb.push_back(e);
    endfunction

    task automatic apply_stimulus(input string nm, input bit sel, input logic [6:0] ctl,
                                  input logic [3:0] d, input logic [3:0] eq,
                                  input logic ew, input logic ec);
        @(negedge clock);
        {clk_en, cnt_en, cin, updown, sclr, sset, sload} = ctl;
        data = d;
        push_exp(nm, sel, eq, ew, ec);
    endtask

    task automatic check_output(input string nm, input bit sel,
                                input logic [3:0] eq, input logic ew, input logic ec);
        push_exp(nm, sel, eq, ew, ec);
        -> sample_ev;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        clk_en = 1'b0;
        aclr   = 1'b0;
    endtask

    initial begin
        {clk_en, cnt_en, cin, updown, sclr, sset, sload} = 7'b1110000;
        data = 4'd0;
        aclr = 1'b1;
        #2;
        check_output("reset_down_cout", 0, 4'd0, 1'b0, 1'b1);
        updown = 1'b1;
        #1;
        check_output("reset_up_cout", 0, 4'd0, 1'b0, 1'b0);
        check_output("reset_b", 1, 4'd0, 1'b0, 1'b0);
        release_reset();

        for (int i = 1; i <= 12; i++)
            apply_stimulus("up_wrap", 0, UP, 4'd0, 4'(i % 10), (i % 10) == 0, (i % 10) == 9);

        apply_stimulus("sclr", 0, 7'b1110100, 4'd0, 4'd0, 1'b0, 1'b1);
        apply_stimulus("down_wrap", 0, DOWN, 4'd0, 4'd9, 1'b1, 1'b0);
        apply_stimulus("down_8", 0, DOWN, 4'd0, 4'd8, 1'b0, 1'b0);
        apply_stimulus("down_7", 0, DOWN, 4'd0, 4'd7, 1'b0, 1'b0);

        apply_stimulus("prio_sclr", 0, 7'b1111111, 4'd5, 4'd0, 1'b0, 1'b0);
        apply_stimulus("prio_sset", 0, 7'b1111011, 4'd5, 4'd9, 1'b0, 1'b1);
        apply_stimulus("load_sat", 0, 7'b1111001, 4'd13, 4'd9, 1'b0, 1'b1);
        apply_stimulus("load_4", 0, 7'b1111001, 4'd4, 4'd4, 1'b0, 1'b0);

        for (int i = 5; i <= 10; i++)
            apply_stimulus("up_to_wrap", 0, UP, 4'd0, 4'(i % 10), (i % 10) == 0, (i % 10) == 9);
        repeat (5)
            apply_stimulus("clk_en_off", 0, 7'b0111100, 4'd0, 4'd0, 1'b1, 1'b0);
        apply_stimulus("cin_off_up", 0, 7'b1101000, 4'd0, 4'd0, 1'b0, 1'b0);
        apply_stimulus("cin_off_down", 0, 7'b1100000, 4'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 1; i <= 6; i++)
            apply_stimulus("up_to_6", 0, UP, 4'd0, 4'(i), 1'b0, 1'b0);
        @(negedge clock);
        aclr = 1'b1;
        #1;
        check_output("async_mid", 0, 4'd0, 1'b0, 1'b0);
        release_reset();

        for (int i = 1; i <= 9; i++)
            apply_stimulus("up_to_9", 0, UP, 4'd0, 4'(i), 1'b0, i == 9);
        @(negedge clock);
        {clk_en, cnt_en, cin, updown, sclr, sset, sload} = UP;
        push_exp("aclr_on_wrap", 0, 4'd0, 1'b0, 1'b0);
        #4 aclr = 1'b1;
        release_reset();

        apply_stimulus("b_sset", 1, 7'b1111010, 4'd0, 4'd15, 1'b0, 1'b1);
        apply_stimulus("b_up_wrap", 1, UP, 4'd0, 4'd0, 1'b1, 1'b0);
        apply_stimulus("b_up_1", 1, UP, 4'd0, 4'd1, 1'b0, 1'b0);
        apply_stimulus("b_down_0", 1, DOWN, 4'd0, 4'd0, 1'b0, 1'b1);
        apply_stimulus("b_down_wrap", 1, DOWN, 4'd0, 4'd15, 1'b1, 1'b0);
        apply_stimulus("b_load_13", 1, 7'b1110001, 4'd13, 4'd13, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending actual %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulus_counter.md
MODULUS_COUNTER -- requirements
Module: modulus_counter

Interface
REQ-001 Parameter lpm_width, default 8: counter width in bits, range 1..32.
REQ-002 Parameter lpm_modulus, default 0: count modulus; 0 means 2**lpm_width; otherwise legal range 2..2**lpm_width.
REQ-003 Parameter lpm_svalue, default 2**lpm_width-1: value loaded by sset; if it is >= the effective modulus, it is clamped to modulus-1 at elaboration.
REQ-004 clock  input  1  rising-edge clock, the only clock.
REQ-005 aclr  input  1  reset, asynchronous, active-high.
REQ-006 clk_en  input  1  gates every synchronous action (sclr, sset, sload, count) when high.
REQ-007 cnt_en  input  1  count enable.
REQ-008 cin  input  1  carry-in; counting requires cnt_en=1 and cin=1.
REQ-009 updown  input  1  1 = count up, 0 = count down.
REQ-010 data  input  lpm_width  value loaded by sload.
REQ-011 sclr  input  1  synchronous clear to 0.
REQ-012 sset  input  1  synchronous set to lpm_svalue.
REQ-013 sload  input  1  synchronous load of data.
REQ-014 q  output  lpm_width  registered count value, always in 0..M-1, where M is the effective modulus.
REQ-015 cout  output  1  combinational terminal-count carry for cascading.
REQ-016 wrap  output  1  registered one-cycle pulse after a wrap-around.

Function
REQ-017 Synchronous priority, evaluated only when clk_en=1: sclr > sset > sload > count > hold.
REQ-018 If clk_en=0, q and wrap hold their values, regardless of all other inputs except aclr.
REQ-019 sclr: q <= 0.
REQ-020 sset: q <= clamped lpm_svalue.
REQ-021 sload: q <= data if data < M; otherwise q <= M-1 (saturating load).
REQ-022 Count up (cnt_en=1, cin=1, updown=1): q <= q+1, except q = M-1, which gives q <= 0.
REQ-023 Count down (cnt_en=1, cin=1, updown=0): q <= q-1, except q = 0, which gives q <= M-1.
REQ-024 If cnt_en=0 or cin=0, no count occurs and q holds.
REQ-025 cout = cin AND cnt_en AND ((updown AND q = M-1) OR (NOT updown AND q = 0)).
- cout is independent of clk_en, sclr, sset and sload.
REQ-026 wrap is set to 1 on a clock edge where clk_en=1 and a counting wrap (REQ-022/023 exception case) occurs.
- On every other edge with clk_en=1, wrap is set to 0.
- wrap never asserts for an sclr, sset or sload action, even if cout was high.
REQ-027 Latency: q and wrap update on the rising clock edge following the qualifying inputs; there is no pipeline delay.
REQ-028 For M = 2**lpm_width, wrap-around is the natural binary overflow; no separate compare logic is required.
REQ-029 updown may change on any cycle; the direction applied is the one sampled at the edge.

Reset
REQ-030 While aclr=1, q = 0 and wrap = 0 immediately, independent of clock and clk_en.
REQ-031 aclr asserted mid-count aborts any pending action; no wrap pulse is produced for that cycle.
REQ-032 After aclr deasserts, the first rising clock edge behaves per REQ-017..REQ-026 from q = 0.
REQ-033 cout follows REQ-025 combinationally during reset (q = 0, so cout = cin AND cnt_en AND NOT updown).

Verification (lpm_width=4, lpm_modulus=10, lpm_svalue default, clamped to 9)
REQ-034 Up-wrap: from reset, count up 12 cycles with cnt_en=cin=clk_en=1 -> q sequence 1..9,0,1,2; cout=1 while q=9; wrap=1 exactly in the cycle that q=0.
REQ-035 Down-wrap: sclr, then count down 3 cycles -> q = 9,8,7; wrap pulses with q=9; cout=1 while q=0 before that edge.
REQ-036 Priority and load: sclr=sset=sload=1 -> q=0; sset=sload=1 -> q=9; sload with data=13 -> q=9; sload with data=4 -> q=4; none of these produce a wrap.
REQ-037 Gating: clk_en=0 with sclr=1 and counting -> q unchanged for 5 cycles; cin=0 with cnt_en=1 -> q holds and cout=0.
REQ-038 Async reset: assert aclr between clock edges at q=6 -> q=0 and wrap=0 before the next edge; q=9 counting up with aclr asserted on the wrap edge -> q=0 and wrap=0.
REQ-039 Default-modulus case (lpm_width=4, lpm_modulus=0) -> up count wraps 15 to 0 with wrap pulse; sset loads 15.
